// File: rtl/ucq_ctrl_pkg.sv
// Shared types for the unit-clause queue controller.
//   lit_t       : signed literal, width `CLA_LENGTH (0 is reserved / "no literal")
//   ucq_state_e : controller state (IDLE, RUN, CONFL)
`ifndef CLA_LENGTH
`define CLA_LENGTH 8
`endif

package ucq_ctrl_pkg;
  typedef logic signed [`CLA_LENGTH-1:0] lit_t;
  typedef enum logic [1:0] {IDLE, RUN, CONFL} ucq_state_e;
endpackage

// File: rtl/ucq_ctrl_lit_cam.sv
// lit_cam: combinational literal CAM over the queue storage, used for
// duplicate and contradiction detection. Built only when UCQ_DEDUP_EN is defined.
//   entries   : DEPTH stored literals
//   valid     : per-entry valid mask
//   probe     : incoming literal
//   match     : probe equals a valid entry
//   neg_match : probe equals the negation of a valid entry
`ifdef UCQ_DEDUP_EN
module lit_cam
  import ucq_ctrl_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  lit_t             entries [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  lit_t             probe,
  output logic             match,
  output logic             neg_match
);
  lit_t neg_probe;

  always_comb begin
    neg_probe = lit_t'(-probe);
    match     = 1'b0;
    neg_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid[i] && entries[i] == probe)     match     = 1'b1;
      if (valid[i] && entries[i] == neg_probe) neg_match = 1'b1;
    end
  end
endmodule
`endif

// File: rtl/ucq_ctrl.sv
// ucq_ctrl: unit-clause queue controller. Circular FIFO of implied and
// decision literals served to the BCP PE, with sticky conflict/overflow.
// Optional macro UCQ_DEDUP_EN: drop duplicate implications and raise
// conflict on contradictory ones (instantiates lit_cam).
// Ports:
//   clk, rst_n (sync, active-high), flush (sync clear, highest priority)
//   imp_valid/imp_lit   : implication push (literal 0 ignored)
//   pe_conflict         : PE conflict report
//   dec_valid/dec_lit   : decision offer; dec_ready (combinational) accepts it
//   pop                 : consume head
//   head_lit, empty, full, count, conflict, overflow : registered status
module ucq_ctrl
  import ucq_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imp_valid,
  input  lit_t             imp_lit,
  input  logic             pe_conflict,
  input  logic             dec_valid,
  input  lit_t             dec_lit,
  output logic             dec_ready,
  input  logic             pop,
  output lit_t             head_lit,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             conflict,
  output logic             overflow,
  input  logic             flush
);
  localparam int AW = $clog2(DEPTH);

  lit_t             mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  ucq_state_e       state_q, state_d;
  lit_t             head_q, head_d;
  logic             empty_q, full_q, conflict_q, overflow_q;

  logic in_confl, imp_try, imp_ins, imp_acc, dec_acc, pop_eff;
  logic conflict_ev, ovf_ev, push, dup, contra;
  lit_t push_lit;

`ifdef UCQ_DEDUP_EN
  logic [DEPTH-1:0] valid;
  logic [AW-1:0]    off;

  // Entry i is live when its distance from the read pointer is below count.
  always_comb begin
    valid = '0;
    off   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off      = AW'(i) - rptr_q;
      valid[i] = (CNT_W'(off) < count_q);
    end
  end

  lit_cam #(.DEPTH(DEPTH)) u_cam (
    .entries   (mem_q),
    .valid     (valid),
    .probe     (imp_lit),
    .match     (dup),
    .neg_match (contra)
  );
`else
  assign dup    = 1'b0;
  assign contra = 1'b0;
`endif

  assign dec_ready = dec_valid && (state_q == IDLE) && !imp_valid && !flush;

  always_comb begin
    in_confl    = (state_q == CONFL);
    imp_try     = imp_valid && (imp_lit != '0) && !in_confl;
    conflict_ev = pe_conflict || (imp_try && contra);
    pop_eff     = pop && (count_q != '0) && !in_confl && !conflict_ev;
    imp_ins     = imp_try && !dup && !conflict_ev;
    // A full queue still accepts a push when the head leaves in the same cycle.
    imp_acc     = imp_ins && ((count_q != CNT_W'(DEPTH)) || pop_eff);
    ovf_ev      = imp_ins && !imp_acc;
    dec_acc     = dec_ready && !conflict_ev;
    push        = imp_acc || dec_acc;
    push_lit    = imp_acc ? imp_lit : dec_lit;

    count_d = count_q;
    if (push && !pop_eff)      count_d = count_q + CNT_W'(1);
    else if (pop_eff && !push) count_d = count_q - CNT_W'(1);
    rptr_d = rptr_q + AW'(pop_eff);

    if (conflict_ev)     state_d = CONFL;
    else if (in_confl)   state_d = CONFL;
    else if (count_d != '0) state_d = RUN;
    else                 state_d = IDLE;

    // Head after the edge is the entry being written when it becomes the
    // only live one, otherwise whatever storage holds at the new read pointer.
    if (state_d == CONFL || count_d == '0) head_d = '0;
    else if (push && rptr_d == wptr_q)     head_d = push_lit;
    else                                   head_d = mem_q[rptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst_n || flush) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      head_q     <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      conflict_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_q + AW'(push);
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      head_q     <= head_d;
      empty_q    <= (count_d == '0) || (state_d == CONFL);
      full_q     <= (count_d == CNT_W'(DEPTH));
      conflict_q <= conflict_q || conflict_ev;
      overflow_q <= overflow_q || ovf_ev;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n && !flush && push) mem_q[wptr_q] <= push_lit;
  end

  assign head_lit = head_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign conflict = conflict_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_ucq_ctrl.sv
module tb_ucq_ctrl;
  import ucq_ctrl_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n, imp_valid, pe_conflict, dec_valid, pop, flush;
  lit_t             imp_lit, dec_lit, head_lit;
  logic             dec_ready, empty, full, conflict, overflow;
  logic [CNT_W-1:0] count;

  int   checks = 0;
  int   errors = 0;
  lit_t sb [$];

  always #5 clk = ~clk;

  ucq_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .imp_valid(imp_valid), .imp_lit(imp_lit),
    .pe_conflict(pe_conflict), .dec_valid(dec_valid), .dec_lit(dec_lit),
    .dec_ready(dec_ready), .pop(pop), .head_lit(head_lit), .empty(empty),
    .full(full), .count(count), .conflict(conflict), .overflow(overflow),
    .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_imp(input lit_t l);
    imp_valid = 1'b1;
    imp_lit   = l;
    step();
    imp_valid = 1'b0;
    imp_lit   = '0;
  endtask

  // Model: enqueue only while the scoreboard has room.
  task automatic push_model(input lit_t l);
    push_imp(l);
    if (sb.size() < DEPTH) sb.push_back(l);
  endtask

  task automatic pop_chk(input string tag);
    lit_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard underflow", tag);
    end else begin
      e = sb.pop_front();
      check(tag, 32'(head_lit), 32'(e));
      check({tag, "_empty"}, 32'(empty), 32'(0));
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_head"},  32'(head_lit), 32'(0));
    check({tag, "_empty"}, 32'(empty),    32'(1));
    check({tag, "_full"},  32'(full),     32'(0));
    check({tag, "_count"}, 32'(count),    32'(0));
    check({tag, "_confl"}, 32'(conflict), 32'(0));
    check({tag, "_ovf"},   32'(overflow), 32'(0));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    sb.delete();
    check_cleared("flush");
  endtask

  initial begin
    rst_n = 1'b1; imp_valid = 1'b0; imp_lit = '0; pe_conflict = 1'b0;
    dec_valid = 1'b0; dec_lit = '0; pop = 1'b0; flush = 1'b0;
    step(); step();
    rst_n = 1'b0;
    check_cleared("reset");

    // Decision accepted in IDLE, then popped.
    dec_valid = 1'b1; dec_lit = 8'sd5;
    #1 check("dec_ready", 32'(dec_ready), 32'(1));
    step();
    dec_valid = 1'b0;
    sb.push_back(8'sd5);
    check("dec_count", 32'(count), 32'(1));
    pop_chk("dec_head");
    check("dec_pop_empty", 32'(empty), 32'(1));
    check("dec_pop_count", 32'(count), 32'(0));

    // Implications in order.
    push_model(8'sd3);
    push_model(-8'sd7);
    push_model(8'sd9);
    check("imp_count", 32'(count), 32'(3));
    for (int i = 0; i < 3; i++) pop_chk("imp_head");
    check("imp_drained_head",  32'(head_lit), 32'(0));
    check("imp_drained_empty", 32'(empty),    32'(1));

    // Fill (pointers start mid-ring, so this wraps), then overflow.
    for (int i = 1; i <= DEPTH; i++) push_model(lit_t'(i));
    check("fill_full",  32'(full),  32'(1));
    check("fill_count", 32'(count), 32'(DEPTH));
    push_model(8'sd11);
    check("ovf_flag",  32'(overflow), 32'(1));
    check("ovf_count", 32'(count),    32'(DEPTH));
    do_flush();

    // Full with simultaneous push and pop.
    for (int i = 1; i <= DEPTH; i++) push_model(lit_t'(20 + i));
    begin
      lit_t e;
      e = sb.pop_front();
      check("pp_head", 32'(head_lit), 32'(e));
      imp_valid = 1'b1; imp_lit = 8'sd11; pop = 1'b1;
      step();
      imp_valid = 1'b0; imp_lit = '0; pop = 1'b0;
      sb.push_back(8'sd11);
    end
    check("pp_ovf",   32'(overflow), 32'(0));
    check("pp_count", 32'(count),    32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) pop_chk("pp_drain");
    check("pp_drained", 32'(empty), 32'(1));

`ifdef UCQ_DEDUP_EN
    push_model(8'sd4);
    push_imp(8'sd4);
    check("dedup_count", 32'(count), 32'(1));
    push_imp(-8'sd4);
    check("contra_confl", 32'(conflict), 32'(1));
    check("contra_empty", 32'(empty),    32'(1));
    push_imp(8'sd8);
    check("contra_hold_count", 32'(count),    32'(1));
    check("contra_hold_empty", 32'(empty),    32'(1));
    do_flush();
`else
    push_model(8'sd4);
    push_model(8'sd4);
    push_model(-8'sd4);
    check("nodedup_count", 32'(count),    32'(3));
    check("nodedup_confl", 32'(conflict), 32'(0));
    for (int i = 0; i < 3; i++) pop_chk("nodedup_head");
`endif

    // Implication beats decision in the same cycle.
    imp_valid = 1'b1; imp_lit = 8'sd2; dec_valid = 1'b1; dec_lit = 8'sd6;
    #1 check("prio_dec_ready", 32'(dec_ready), 32'(0));
    step();
    imp_valid = 1'b0; imp_lit = '0; dec_valid = 1'b0;
    sb.push_back(8'sd2);
    check("prio_head",  32'(head_lit), 32'(2));
    check("prio_count", 32'(count),    32'(1));

    // Sticky PE conflict.
    pe_conflict = 1'b1;
    step();
    pe_conflict = 1'b0;
    check("pe_confl",       32'(conflict), 32'(1));
    check("pe_confl_empty", 32'(empty),    32'(1));
    check("pe_confl_head",  32'(head_lit), 32'(0));
    pop = 1'b1;
    step();
    pop = 1'b0;
    check("pe_confl_sticky", 32'(conflict), 32'(1));
    check("pe_confl_count",  32'(count),    32'(1));
    do_flush();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
